// File: rtl/mem_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_sequencer
// Brief    : Serializes vector/scalar M-stage accesses onto a byte-wide
//            data memory port and stalls the pipeline until they finish.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_sequencer #(
  parameter int LANES  = 8,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite_M,
  input  logic                    MemtoReg_M,
  input  logic                    is_vector_M,
  input  logic                    abort_M,
  input  logic [ADDR_W-1:0]       ALUResult_M,
  input  logic [LANES*LANE_W-1:0] store_data_M,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic                    mem_gnt,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    stall_M,
  output logic [LANES*LANE_W-1:0] load_data,
  output logic                    load_valid,
  output logic                    busy
);

  localparam int c_IDX_W = $clog2(LANES + 1);
  localparam int c_SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_STORE = 3'd1;
  localparam logic [2:0] c_ST_LOAD  = 3'd2;
  localparam logic [2:0] c_ST_LWAIT = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              w_state_next;
  logic [c_IDX_W-1:0]      r_index;
  logic [c_IDX_W-1:0]      r_count;
  logic [ADDR_W-1:0]       r_base;
  logic [LANES*LANE_W-1:0] r_store_data;
  logic [LANES*LANE_W-1:0] r_acc;
  logic [LANES*LANE_W-1:0] w_acc_next;
  logic [LANES*LANE_W-1:0] r_load_data;
  logic                    r_is_load;
  logic                    r_cap_pending;
  logic [c_SEL_W-1:0]      r_cap_sel;
  logic [c_SEL_W-1:0]      w_sel;
  logic                    w_start;
  logic                    w_last;
  logic                    w_active;
  logic [LANE_W-1:0]       w_lane [LANES];

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane[g] = r_store_data[g*LANE_W +: LANE_W];
    end
  endgenerate

  // Start is gated by reset so every output reads 0 while reset is held.
  assign w_start  = !reset && (r_state == c_ST_IDLE) &&
                    (MemWrite_M || MemtoReg_M) && !abort_M;
  assign w_sel    = r_index[c_SEL_W-1:0];
  assign w_last   = (r_index == (r_count - c_IDX_W'(1)));
  assign w_active = (r_state == c_ST_STORE) || (r_state == c_ST_LOAD);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_start) w_state_next = MemWrite_M ? c_ST_STORE : c_ST_LOAD;
      c_ST_STORE: if (mem_gnt && w_last) w_state_next = c_ST_DONE;
      c_ST_LOAD:  if (mem_gnt && w_last) w_state_next = c_ST_LWAIT;
      c_ST_LWAIT: w_state_next = c_ST_DONE;
      c_ST_DONE:  w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // Read data arrives one cycle after its grant; merge it into the lane
  // remembered from that grant.
  always_comb begin
    w_acc_next = r_acc;
    if (r_cap_pending) begin
      w_acc_next[r_cap_sel*LANE_W +: LANE_W] = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_ST_IDLE;
      r_index       <= '0;
      r_count       <= '0;
      r_base        <= '0;
      r_store_data  <= '0;
      r_acc         <= '0;
      r_load_data   <= '0;
      r_is_load     <= 1'b0;
      r_cap_pending <= 1'b0;
      r_cap_sel     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cap_pending <= (r_state == c_ST_LOAD) && mem_gnt;
      r_cap_sel     <= w_sel;
      if (w_start) begin
        r_base       <= ALUResult_M;
        r_store_data <= store_data_M;
        r_count      <= is_vector_M ? c_IDX_W'(LANES) : c_IDX_W'(1);
        r_is_load    <= !MemWrite_M;
        r_index      <= '0;
        r_acc        <= '0;
      end else begin
        r_acc <= w_acc_next;
        if (w_active && mem_gnt) begin
          r_index <= w_last ? '0 : r_index + c_IDX_W'(1);
        end
      end
      if (r_state == c_ST_LWAIT) begin
        r_load_data <= w_acc_next;
      end
    end
  end

  assign mem_req    = w_active;
  assign mem_we     = (r_state == c_ST_STORE);
  assign mem_addr   = w_active ? (r_base + ADDR_W'(r_index)) : '0;
  assign mem_wdata  = (r_state == c_ST_STORE) ? w_lane[w_sel] : '0;
  assign stall_M    = w_start || w_active || (r_state == c_ST_LWAIT);
  assign load_valid = (r_state == c_ST_DONE) && r_is_load;
  assign load_data  = r_load_data;
  assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lane_sequencer
// Brief    : Directed plus randomized transactions against a byte memory and
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lane_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite_M, MemtoReg_M, is_vector_M, abort_M;
  logic [15:0] ALUResult_M;
  logic [63:0] store_data_M;
  logic        mem_req, mem_we, mem_gnt, stall_M, load_valid, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [63:0] load_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  env_mem [0:65535];
  bit          env_wr  [0:65535];
  logic [7:0]  ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  logic [63:0] last_load;

  mem_lane_sequencer dut (
    .clk(clk), .reset(reset),
    .MemWrite_M(MemWrite_M), .MemtoReg_M(MemtoReg_M),
    .is_vector_M(is_vector_M), .abort_M(abort_M),
    .ALUResult_M(ALUResult_M), .store_data_M(store_data_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .stall_M(stall_M), .load_data(load_data), .load_valid(load_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Contents of never-written locations.
  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        env_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : dflt(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One M-stage access from request to the first idle cycle after DONE.
  task automatic run_txn(input bit wr, input bit rd, input bit vec,
                         input logic [15:0] base, input logic [63:0] data,
                         input int pct, input int hold_low);
    int          cnt, k, cyc;
    bit          is_st, is_ld;
    logic [15:0] a;
    logic [63:0] exp_ld;
    is_st = wr;
    is_ld = rd && !wr;
    cnt   = vec ? 8 : 1;
    @(posedge clk); #1;
    MemWrite_M = wr; MemtoReg_M = rd; is_vector_M = vec; abort_M = 1'b0;
    ALUResult_M = base; store_data_M = data; mem_gnt = 1'b1;
    #1;
    chk("start_stall", stall_M, 1);
    chk("start_req", mem_req, 0);
    chk("start_busy", busy, 0);
    k = 0;
    cyc = 0;
    while (k < cnt) begin
      @(posedge clk); #1;
      ALUResult_M  = 16'($urandom);
      store_data_M = {$urandom, $urandom};
      abort_M      = 1'($urandom_range(1));
      mem_gnt      = (cyc < hold_low) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      a = base + 16'(k);
      chk("acc_req", mem_req, 1);
      chk("acc_we", mem_we, is_st);
      chk("acc_addr", mem_addr, a);
      if (is_st) chk("acc_wdata", mem_wdata, data[k*8 +: 8]);
      chk("acc_stall", stall_M, 1);
      chk("acc_valid", load_valid, 0);
      if (mem_gnt) begin
        if (is_st) begin
          ref_mem[a] = data[k*8 +: 8];
          ref_wr[a]  = 1'b1;
        end
        k++;
      end
      cyc++;
    end
    if (is_ld) begin
      @(posedge clk); #1;
      mem_gnt = 1'($urandom_range(1));
      #1;
      chk("lwait_req", mem_req, 0);
      chk("lwait_stall", stall_M, 1);
      chk("lwait_busy", busy, 1);
    end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    abort_M = 1'b0;
    #1;
    chk("done_stall", stall_M, 0);
    chk("done_req", mem_req, 0);
    chk("done_busy", busy, 1);
    chk("done_valid", load_valid, is_ld);
    if (is_ld) begin
      exp_ld = '0;
      for (int i = 0; i < cnt; i++) exp_ld[i*8 +: 8] = ref_rd(base + 16'(i));
      last_load = exp_ld;
    end
    chk("done_data", load_data, last_load);
    @(posedge clk); #1;
    MemWrite_M = 1'b0; MemtoReg_M = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", load_valid, 0);
    chk("idle_stall", stall_M, 0);
    chk("hold_data", load_data, last_load);
  endtask

  initial begin
    reset = 1'b1;
    MemWrite_M = 1'b0; MemtoReg_M = 1'b0; is_vector_M = 1'b0; abort_M = 1'b0;
    ALUResult_M = '0; store_data_M = '0; mem_gnt = 1'b0;
    last_load = '0;
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", stall_M, 0);
    chk("rst_data", load_data, 0);
    chk("rst_valid", load_valid, 0);
    chk("rst_busy", busy, 0);
    #1 reset = 1'b0;

    run_txn(1, 0, 1, 16'h0100, 64'h8877665544332211, 100, 0);
    run_txn(1, 0, 1, 16'h0200, 64'hA7A6A5A4A3A2A1A0, 100, 0);
    run_txn(0, 1, 1, 16'h0200, 64'h0, 100, 0);
    chk("tp_vload", load_data, 64'hA7A6A5A4A3A2A1A0);
    run_txn(1, 0, 0, 16'h0010, 64'h5C, 100, 0);
    run_txn(0, 1, 0, 16'h0010, 64'h0, 100, 3);
    chk("tp_sload", load_data, 64'h000000000000005C);

    run_txn(1, 1, 1, 16'hFFFC, {$urandom, $urandom}, 100, 0);
    run_txn(0, 1, 1, 16'hFFFC, 64'h0, 70, 1);

    // Aborted request in IDLE must never start.
    @(posedge clk); #1;
    MemWrite_M = 1'b1; is_vector_M = 1'b1; abort_M = 1'b1; ALUResult_M = 16'h0500;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_req", mem_req, 0);
      chk("abort_stall", stall_M, 0);
      chk("abort_busy", busy, 0);
      @(posedge clk); #1;
    end
    MemWrite_M = 1'b0; abort_M = 1'b0;
    run_txn(1, 0, 1, 16'h0500, {$urandom, $urandom}, 100, 0);
    run_txn(0, 1, 1, 16'h0500, 64'h0, 100, 0);

    for (int t = 0; t < 24; t++) begin
      bit          wr, rd, vec;
      logic [15:0] base;
      wr   = 1'($urandom_range(1));
      rd   = wr ? 1'($urandom_range(1)) : 1'b1;
      vec  = 1'($urandom_range(1));
      base = ($urandom_range(3) == 0) ? 16'hFFF8 + 16'($urandom_range(7))
                                      : 16'h4000 + 16'($urandom_range(31));
      run_txn(wr, rd, vec, base, {$urandom, $urandom},
              $urandom_range(30, 100), $urandom_range(2));
    end

    // Reset in the middle of a vector load, at index 4.
    @(posedge clk); #1;
    MemtoReg_M = 1'b1; is_vector_M = 1'b1; ALUResult_M = 16'h0300; mem_gnt = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    #1 chk("mid_addr", mem_addr, 16'h0304);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_stall", stall_M, 0);
    chk("arst_data", load_data, 0);
    chk("arst_valid", load_valid, 0);
    chk("arst_busy", busy, 0);
    MemtoReg_M = 1'b0; mem_gnt = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    last_load = '0;
    run_txn(1, 0, 0, 16'h0777, 64'hE1, 100, 0);
    run_txn(0, 1, 0, 16'h0777, 64'h0, 100, 0);
    chk("post_rst_load", load_data, 64'h00000000000000E1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
